// File: rtl/mem4_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem4_arb_pkg;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int        MEM_DEPTH = 256;
  localparam logic [7:0] CLR_VALUE = '0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; combinational one-hot grant, `last` pointer
// tracks the most recently served port and resets to 1 so port 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last;

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last <= 1'b1;
    else if (advance) last <= gnt[1];
  end

endmodule

// File: rtl/mem4_arb.sv
// Arbitrates two requesters onto one registered memory port and returns read data
// two edges after acceptance. MEM4_ARB_CLEAR_EN compiles in the zero-fill sweep engine.
module mem4_arb
  import mem4_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_out,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done
);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              arb_en;
  logic [1:0]        gnt;
  logic              xfer;
  logic              sel;
  logic              sel_we;
  logic              rd_pend;
  logic              rd_tag;

`ifdef MEM4_ARB_CLEAR_EN
  state_t state_nxt;
  logic   clr_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ARB;
    else        state <= state_nxt;
  end

  // clr_start beats pending requests: no grant in the cycle it is seen.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    clr_last  = 1'b0;
    case (state)
      ST_ARB: begin
        if (clr_start) state_nxt = ST_CLEAR;
        else           arb_en    = 1'b1;
      end
      ST_CLEAR: begin
        clr_last = (cnt == ADDR_W'(MEM_DEPTH - 1));
        if (clr_last) state_nxt = ST_ARB;
      end
      default: state_nxt = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      if (state == ST_CLEAR) cnt <= cnt + 1'b1;
      clr_done <= clr_last;
    end
  end

  assign clr_busy = (state == ST_CLEAR);
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign state            = ST_ARB;
  assign arb_en           = 1'b1;
  assign cnt              = '0;
  assign clr_busy         = 1'b0;
  assign clr_done         = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1, req0}),
    .advance (xfer),
    .enable  (arb_en),
    .gnt     (gnt)
  );

  assign gnt0   = gnt[0];
  assign gnt1   = gnt[1];
  assign xfer   = |gnt;
  assign sel    = gnt[1];
  assign sel_we = sel ? we1 : we0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else if (xfer) begin
      mem_we   <= sel_we;
      mem_addr <= sel ? addr1 : addr0;
      mem_data <= sel ? wdata1 : wdata0;
    end else if (state == ST_CLEAR) begin
      mem_we   <= 1'b1;
      mem_addr <= cnt;
      mem_data <= DATA_W'(CLR_VALUE);
    end else begin
      mem_we   <= 1'b0;
    end
  end

  // Owner tag travels with the read so mem_out lands on the right port next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rd_pend <= xfer && !sel_we;
      if (xfer) rd_tag <= sel;
      rvalid0 <= rd_pend && !rd_tag;
      rvalid1 <= rd_pend && rd_tag;
      if (rd_pend && !rd_tag) rdata0 <= mem_out;
      if (rd_pend && rd_tag)  rdata1 <= mem_out;
    end
  end

endmodule

// File: tb/tb_mem4_arb.sv
// Directed bench for mem4_arb with a behavioural 256 x 8 memory on the port.
module tb_mem4_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       mem_we;
  logic [7:0] mem_addr, mem_data, mem_out;
  logic       clr_start, clr_busy, clr_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [256];
  logic [7:0] waddr [4];
  logic [7:0] clr_exp;
  int busy_n, viol_n, done_n, guard;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;
  assign mem_out = mem[mem_addr];

  mem4_arb #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    waddr[0] = 8'h00; waddr[1] = 8'h7F; waddr[2] = 8'h80; waddr[3] = 8'hFF;
`ifdef MEM4_ARB_CLEAR_EN
    clr_exp = 8'h00;
`else
    clr_exp = 8'hFF;
`endif
    rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; clr_start = 0;
    tick; tick;
    chk("rst_gnt",    {gnt1, gnt0}, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_rdata",  {rdata1, rdata0}, 0);
    chk("rst_memport", {mem_we, mem_addr, mem_data}, 0);
    chk("rst_clr",    {clr_busy, clr_done}, 0);
    rst_n = 1'b1;
    tick;

    // single write through port 0
    req0 = 1; we0 = 1; addr0 = 8'h45; wdata0 = 8'hA5; settle;
    chk("wr0_gnt", {gnt1, gnt0}, 2'b01);
    tick; req0 = 0;
    chk("wr0_issue", {mem_we, mem_addr, mem_data}, {1'b1, 8'h45, 8'hA5});
    settle;
    chk("wr0_gnt_drop", {gnt1, gnt0}, 2'b00);

    // write via port 1 then back-to-back read via port 0
    req1 = 1; we1 = 1; addr1 = 8'hC1; wdata1 = 8'h3C; settle;
    chk("wr1_gnt", {gnt1, gnt0}, 2'b10);
    tick; req1 = 0; req0 = 1; we0 = 0; addr0 = 8'hC1; settle;
    chk("raw_rd_gnt", {gnt1, gnt0}, 2'b01);
    chk("raw_wr_issue", {mem_we, mem_addr, mem_data}, {1'b1, 8'hC1, 8'h3C});
    tick; req0 = 0;
    chk("raw_rd_issue", {mem_we, mem_addr, rvalid1, rvalid0}, {1'b0, 8'hC1, 2'b00});
    tick;
    chk("raw_rvalid", {rvalid1, rvalid0}, 2'b01);
    chk("raw_rdata0", rdata0, 8'h3C);
    tick;
    chk("raw_rvalid_pulse", {rvalid1, rvalid0}, 2'b00);

    // port 1 write so port 1 is the last served before the tie
    req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'h11; settle;
    chk("pre_tie_gnt", {gnt1, gnt0}, 2'b10);
    tick; req1 = 0;

    // both held: grants alternate 0,1,0,1
    req0 = 1; we0 = 0; addr0 = 8'h45;
    req1 = 1; we1 = 0; addr1 = 8'hC1; settle;
    chk("tie_gnt_a", {gnt1, gnt0}, 2'b01);
    tick; addr0 = 8'h10; settle;
    chk("tie_gnt_b", {gnt1, gnt0}, 2'b10);
    tick; addr1 = 8'h45;
    chk("tie_ret_a", {rvalid1, rvalid0, rdata0}, {2'b01, 8'hA5});
    settle;
    chk("tie_gnt_c", {gnt1, gnt0}, 2'b01);
    tick; we0 = 1; addr0 = 8'h20; wdata0 = 8'h5A;
    chk("tie_ret_b", {rvalid1, rvalid0, rdata1}, {2'b10, 8'h3C});
    settle;
    chk("tie_gnt_d", {gnt1, gnt0}, 2'b10);
    tick; req1 = 0;
    chk("tie_ret_c", {rvalid1, rvalid0, rdata0}, {2'b01, 8'h11});
    settle;
    chk("tie_gnt_e", {gnt1, gnt0}, 2'b01);
    tick; req0 = 0;
    chk("tie_ret_d", {rvalid1, rvalid0, rdata1}, {2'b10, 8'hA5});
    chk("tie_wr_issue", {mem_we, mem_addr, mem_data}, {1'b1, 8'h20, 8'h5A});
    tick;
    chk("tie_idle", {rvalid1, rvalid0, mem_we}, 3'b000);

    // fill boundary addresses with 0xFF
    req0 = 1; we0 = 1; wdata0 = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      addr0 = waddr[i]; settle;
      chk("fill_gnt", {gnt1, gnt0}, 2'b01);
      tick;
    end
    req0 = 0;

    // clear request with port 1 read pending
    clr_start = 1; req1 = 1; we1 = 0; addr1 = 8'h7F; settle;
`ifdef MEM4_ARB_CLEAR_EN
    chk("clr_start_gnt", {gnt1, gnt0}, 2'b00);
    tick; clr_start = 0;
    busy_n = 0; viol_n = 0; done_n = 0; guard = 0;
    while (clr_busy && guard < 400) begin
      busy_n++;
      if (gnt1) viol_n++;
      if (clr_done) done_n++;
      clr_start = (busy_n == 100);
      tick;
      guard++;
    end
    clr_start = 0;
    chk("clr_busy_len", busy_n, 256);
    chk("clr_gnt_blocked", viol_n, 0);
    chk("clr_done_early", done_n, 0);
    chk("clr_done_pulse", clr_done, 1'b1);
    chk("clr_first_arb_gnt", {gnt1, gnt0}, 2'b10);
    tick; req1 = 0;
    chk("clr_done_once", {clr_busy, clr_done}, 2'b00);
`else
    chk("noclr_gnt", {gnt1, gnt0}, 2'b10);
    chk("noclr_busy", clr_busy, 1'b0);
    tick; clr_start = 0; req1 = 0;
    chk("noclr_flags", {clr_busy, clr_done}, 2'b00);
`endif
    req0 = 1; we0 = 0; addr0 = 8'h00; settle;
    chk("post_rd_gnt", {gnt1, gnt0}, 2'b01);
    tick; addr0 = 8'hFF;
    chk("post_rd_7f", {rvalid1, rvalid0, rdata1}, {2'b10, clr_exp});
    settle; tick; req0 = 0;
    chk("post_rd_00", {rvalid1, rvalid0, rdata0}, {2'b01, clr_exp});
    tick;
    chk("post_rd_ff", {rvalid1, rvalid0, rdata0}, {2'b01, clr_exp});
    tick;
    chk("post_rd_idle", {rvalid1, rvalid0}, 2'b00);

    // reset during an in-flight read
    req0 = 1; we0 = 0; addr0 = 8'hC1; settle;
    tick; req0 = 0; rst_n = 0; settle;
    chk("rst_rd_out", {rvalid1, rvalid0, rdata0, mem_addr}, 0);
    tick; tick;
    chk("rst_rd_no_rvalid", {rvalid1, rvalid0}, 2'b00);
    rst_n = 1; settle;
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h45; addr1 = 8'h45; settle;
    chk("rst_last_tie", {gnt1, gnt0}, 2'b01);
    tick; req0 = 0; settle;
    chk("rst_second_gnt", {gnt1, gnt0}, 2'b10);
    tick; req1 = 0; tick; tick;

`ifdef MEM4_ARB_CLEAR_EN
    // reset during the sweep
    clr_start = 1; tick; clr_start = 0;
    repeat (10) tick;
    chk("mid_clr_busy", clr_busy, 1'b1);
    rst_n = 0; settle;
    chk("mid_clr_rst", {clr_busy, clr_done, mem_we}, 3'b000);
    tick; rst_n = 1;
    done_n = 0;
    for (int i = 0; i < 300; i++) begin
      if (clr_busy || clr_done) done_n++;
      tick;
    end
    chk("mid_clr_dropped", done_n, 0);
`else
    clr_start = 1; req0 = 1; we0 = 0; addr0 = 8'h45; settle;
    chk("noclr2_gnt", {gnt1, gnt0}, 2'b01);
    tick; clr_start = 0; req0 = 0;
    chk("noclr2_flags", {clr_busy, clr_done}, 2'b00);
    tick;
    chk("noclr2_rd", {rvalid0, rdata0}, {1'b1, 8'hA5});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
